// File: rtl/trn_chnnl_cmbnr_pkg.sv
// Shared constants and FSM state types for the TRN_CHNNL_CMBNR AXI4-Lite register bank.
package trn_chnnl_cmbnr_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [2:0] CTRL0 = 3'd0;
  localparam logic [2:0] CTRL1 = 3'd1;
  localparam logic [2:0] CTRL2 = 3'd2;
  localparam logic [2:0] CTRL3 = 3'd3;
  localparam logic [2:0] STAT0 = 3'd4;
  localparam logic [2:0] STAT1 = 3'd5;
  localparam logic [2:0] STAT2 = 3'd6;
  localparam logic [2:0] STAT3 = 3'd7;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_ADDR,
    WR_HAVE_DATA,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

endpackage

// File: rtl/trn_chnnl_cmbnr_axil_wr_ch.sv
// AXI4-Lite write channel: accepts AW and W in either order, emits a one-cycle commit
// strobe with register index/data/strobes, then returns the B response.
module trn_chnnl_cmbnr_axil_wr_ch
  import trn_chnnl_cmbnr_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int NUM_RW_REGS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_awaddr,
  input  logic              i_awvalid,
  output logic              o_awready,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_wstrb,
  input  logic              i_wvalid,
  output logic              o_wready,
  output logic [1:0]        o_bresp,
  output logic              o_bvalid,
  input  logic              i_bready,
  output logic              o_commit,
  output logic [2:0]        o_commit_idx,
  output logic [31:0]       o_commit_data,
  output logic [3:0]        o_commit_strb
);

  wr_state_t   r_state, w_next;
  logic [2:0]  r_idx;
  logic [31:0] r_data;
  logic [3:0]  r_strb;
  logic [1:0]  r_bresp;
  logic        r_bvalid;
  logic        w_aw_hs, w_w_hs, w_commit;
  logic        w_unused;

  assign w_unused  = ^i_awaddr[1:0];
  assign o_awready = ((r_state == WR_IDLE) || (r_state == WR_HAVE_DATA)) && !i_rst;
  assign o_wready  = ((r_state == WR_IDLE) || (r_state == WR_HAVE_ADDR)) && !i_rst;
  assign w_aw_hs   = i_awvalid && o_awready;
  assign w_w_hs    = i_wvalid && o_wready;

  // A channel handshaking this cycle supplies its fields live; otherwise use the latch.
  assign o_commit      = w_commit;
  assign o_commit_idx  = w_aw_hs ? i_awaddr[4:2] : r_idx;
  assign o_commit_data = w_w_hs ? i_wdata : r_data;
  assign o_commit_strb = w_w_hs ? i_wstrb : r_strb;
  assign o_bresp       = r_bresp;
  assign o_bvalid      = r_bvalid;

  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    case (r_state)
      WR_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_commit = 1'b1;
          w_next   = WR_RESP;
        end else if (w_aw_hs) begin
          w_next = WR_HAVE_ADDR;
        end else if (w_w_hs) begin
          w_next = WR_HAVE_DATA;
        end
      end
      WR_HAVE_ADDR: if (w_w_hs) begin
        w_commit = 1'b1;
        w_next   = WR_RESP;
      end
      WR_HAVE_DATA: if (w_aw_hs) begin
        w_commit = 1'b1;
        w_next   = WR_RESP;
      end
      WR_RESP: if (r_bvalid && i_bready) w_next = WR_IDLE;
      default: w_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= WR_IDLE;
      r_idx    <= '0;
      r_data   <= '0;
      r_strb   <= '0;
      r_bresp  <= AXI_RESP_OKAY;
      r_bvalid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_aw_hs) r_idx <= i_awaddr[4:2];
      if (w_w_hs) begin
        r_data <= i_wdata;
        r_strb <= i_wstrb;
      end
      if (w_commit)
        r_bresp <= ({29'd0, o_commit_idx} >= 32'(NUM_RW_REGS)) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      // BVALID rises one edge after entering WR_RESP.
      if ((r_state == WR_RESP) && !r_bvalid) r_bvalid <= 1'b1;
      else if (r_bvalid && i_bready)         r_bvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/trn_chnnl_cmbnr_axil_slave_regs.sv
// AXI4-Lite slave holding the combiner's RW control registers and RO status words;
// independent write and read channels, one transaction outstanding on each.
module trn_chnnl_cmbnr_axil_slave_regs
  import trn_chnnl_cmbnr_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_RW_REGS        = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [NUM_RW_REGS*32-1:0]         ctrl_regs,
  output logic [NUM_RW_REGS-1:0]            ctrl_wr_pulse,
  input  logic [(8-NUM_RW_REGS)*32-1:0]     status_regs
);

  logic [NUM_RW_REGS-1:0][31:0] r_regs;
  logic [NUM_RW_REGS-1:0]       r_wr_pulse;
  logic [7:0][31:0]             w_all;
  logic                         w_commit;
  logic [2:0]                   w_commit_idx;
  logic [31:0]                  w_commit_data;
  logic [3:0]                   w_commit_strb;
  rd_state_t                    r_rd_state, w_rd_next;
  logic [31:0]                  r_rdata;
  logic                         w_ar_hs;
  logic [2:0]                   w_rd_idx;
  logic                         w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0]};

  trn_chnnl_cmbnr_axil_wr_ch #(
    .ADDR_W      (C_S_AXI_ADDR_WIDTH),
    .NUM_RW_REGS (NUM_RW_REGS)
  ) u_wr_ch (
    .i_clk         (ACLK),
    .i_rst         (ARESET),
    .i_awaddr      (S_AXI_AWADDR),
    .i_awvalid     (S_AXI_AWVALID),
    .o_awready     (S_AXI_AWREADY),
    .i_wdata       (S_AXI_WDATA),
    .i_wstrb       (S_AXI_WSTRB),
    .i_wvalid      (S_AXI_WVALID),
    .o_wready      (S_AXI_WREADY),
    .o_bresp       (S_AXI_BRESP),
    .o_bvalid      (S_AXI_BVALID),
    .i_bready      (S_AXI_BREADY),
    .o_commit      (w_commit),
    .o_commit_idx  (w_commit_idx),
    .o_commit_data (w_commit_data),
    .o_commit_strb (w_commit_strb)
  );

  // RO targets never match a loop index here, so they commit nothing.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_regs     <= '0;
      r_wr_pulse <= '0;
    end else begin
      for (int n = 0; n < NUM_RW_REGS; n++) begin
        r_wr_pulse[n] <= w_commit && (w_commit_idx == 3'(n));
        if (w_commit && (w_commit_idx == 3'(n)))
          for (int b = 0; b < 4; b++)
            if (w_commit_strb[b]) r_regs[n][8*b +: 8] <= w_commit_data[8*b +: 8];
      end
    end
  end

  assign ctrl_regs     = r_regs;
  assign ctrl_wr_pulse = r_wr_pulse;

  assign w_all         = {status_regs, r_regs};
  assign w_rd_idx      = S_AXI_ARADDR[4:2];
  assign S_AXI_ARREADY = (r_rd_state == RD_IDLE) && !ARESET;
  assign w_ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
  assign S_AXI_RVALID  = (r_rd_state == RD_DATA);
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = AXI_RESP_OKAY;

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (w_ar_hs) w_rd_next = RD_DATA;
      RD_DATA: if (S_AXI_RREADY) w_rd_next = RD_IDLE;
      default: w_rd_next = RD_IDLE;
    endcase
  end

  // RDATA samples the register array before any same-edge write lands.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rd_state <= RD_IDLE;
      r_rdata    <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      if (w_ar_hs) r_rdata <= w_all[w_rd_idx];
    end
  end

endmodule
